// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
// A request (d_readM or d_writeM) stays asserted until the rising edge on which d_ack=1 is sampled.
interface mem_access_stage_if #(parameter int WORD_SIZE = 16) ();
    logic                 d_readM;
    logic                 d_writeM;
    logic [WORD_SIZE-1:0] d_address;
    logic [WORD_SIZE-1:0] d_data_out;
    logic [WORD_SIZE-1:0] d_data_in;
    logic                 d_ack;

    modport master (
        output d_readM, d_writeM, d_address, d_data_out,
        input  d_data_in, d_ack
    );

    modport slave (
        input  d_readM, d_writeM, d_address, d_data_out,
        output d_data_in, d_ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: EX/MEM latch plus an IDLE/WAIT/DONE access FSM that stalls upstream
// stages while a load or store is outstanding on the data-memory bus.
module mem_access_stage #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ex_valid,
    input  logic [WORD_SIZE-1:0] ex_alu_result,
    input  logic [WORD_SIZE-1:0] ex_store_data,
    input  logic [1:0]           ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 ex_mem_write,
    input  logic                 ex_mem_to_reg,
    input  logic                 ex_reg_write,
    input  logic                 ex_is_wwd,
    output logic                 mem_stall,
    mem_access_stage_if.master   dmem,
    output logic                 wb_valid,
    output logic                 wb_mem_to_reg,
    output logic                 wb_reg_write,
    output logic                 wb_is_wwd,
    output logic [WORD_SIZE-1:0] wb_mem_data,
    output logic [WORD_SIZE-1:0] wb_alu_result,
    output logic [1:0]           wb_rd,
    output logic                 fwd_reg_write,
    output logic [1:0]           fwd_rd,
    output logic [WORD_SIZE-1:0] fwd_value,
    output logic [1:0]           fsm_state
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    logic                 l_valid;
    logic [WORD_SIZE-1:0] l_alu_result;
    logic [WORD_SIZE-1:0] l_store_data;
    logic [1:0]           l_rd;
    logic                 l_mem_read;
    logic                 l_mem_write;
    logic                 l_mem_to_reg;
    logic                 l_reg_write;
    logic                 l_is_wwd;
    logic [WORD_SIZE-1:0] mem_data;
    logic [1:0]           state;

    logic is_mem;
    logic req_active;

    assign is_mem     = l_valid & (l_mem_read | l_mem_write);
    assign req_active = is_mem & ((state == ST_IDLE) | (state == ST_WAIT));

    // d_ack is only meaningful in WAIT; IDLE always spends one cycle presenting the request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            l_valid      <= 1'b0;
            l_alu_result <= '0;
            l_store_data <= '0;
            l_rd         <= 2'b00;
            l_mem_read   <= 1'b0;
            l_mem_write  <= 1'b0;
            l_mem_to_reg <= 1'b0;
            l_reg_write  <= 1'b0;
            l_is_wwd     <= 1'b0;
            mem_data     <= '0;
            state        <= ST_IDLE;
        end else begin
            if (!mem_stall) begin
                l_valid      <= ex_valid;
                l_alu_result <= ex_alu_result;
                l_store_data <= ex_store_data;
                l_rd         <= ex_rd;
                l_mem_read   <= ex_mem_read;
                l_mem_write  <= ex_mem_write;
                l_mem_to_reg <= ex_mem_to_reg;
                l_reg_write  <= ex_reg_write;
                l_is_wwd     <= ex_is_wwd;
            end
            case (state)
                ST_IDLE: if (is_mem) state <= ST_WAIT;
                ST_WAIT: begin
                    if (dmem.d_ack) begin
                        state <= ST_DONE;
                        if (l_mem_read) mem_data <= dmem.d_data_in;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign mem_stall       = req_active;
    assign dmem.d_readM    = req_active & l_mem_read;
    // A dual-control op is executed as a read only.
    assign dmem.d_writeM   = req_active & l_mem_write & ~l_mem_read;
    assign dmem.d_address  = req_active ? l_alu_result : '0;
    assign dmem.d_data_out = req_active ? l_store_data : '0;

    assign wb_valid      = l_valid & (~is_mem | (state == ST_DONE));
    assign wb_mem_to_reg = wb_valid & l_mem_to_reg;
    assign wb_reg_write  = wb_valid & l_reg_write;
    assign wb_is_wwd     = wb_valid & l_is_wwd;
    assign wb_mem_data   = mem_data;
    assign wb_alu_result = l_alu_result;
    assign wb_rd         = l_rd;

    assign fwd_reg_write = l_valid & l_reg_write & ~l_mem_to_reg;
    assign fwd_rd        = l_rd;
    assign fwd_value     = l_alu_result;
    assign fsm_state     = state;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: driver issues EX ops and memory acks, a monitor
// compares every retired (wb_valid) op against a queue of hand-computed results.
module tb_mem_access_stage;
  localparam int W    = 16;
  localparam int WB_W = 3 + 2 + W + W;

  logic          clk;
  logic          reset_n;
  logic          ex_valid;
  logic [W-1:0]  ex_alu_result;
  logic [W-1:0]  ex_store_data;
  logic [1:0]    ex_rd;
  logic          ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_is_wwd;
  logic          mem_stall;
  logic          wb_valid, wb_mem_to_reg, wb_reg_write, wb_is_wwd;
  logic [W-1:0]  wb_mem_data, wb_alu_result;
  logic [1:0]    wb_rd;
  logic          fwd_reg_write;
  logic [1:0]    fwd_rd;
  logic [W-1:0]  fwd_value;
  logic [1:0]    fsm_state;

  mem_access_stage_if #(.WORD_SIZE(W)) dmem ();

  mem_access_stage #(.WORD_SIZE(W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ex_valid      (ex_valid),
    .ex_alu_result (ex_alu_result),
    .ex_store_data (ex_store_data),
    .ex_rd         (ex_rd),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_reg_write  (ex_reg_write),
    .ex_is_wwd     (ex_is_wwd),
    .mem_stall     (mem_stall),
    .dmem          (dmem),
    .wb_valid      (wb_valid),
    .wb_mem_to_reg (wb_mem_to_reg),
    .wb_reg_write  (wb_reg_write),
    .wb_is_wwd     (wb_is_wwd),
    .wb_mem_data   (wb_mem_data),
    .wb_alu_result (wb_alu_result),
    .wb_rd         (wb_rd),
    .fwd_reg_write (fwd_reg_write),
    .fwd_rd        (fwd_rd),
    .fwd_value     (fwd_value),
    .fsm_state     (fsm_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  int checks   = 0;
  int failures = 0;
  logic [WB_W-1:0] exp_q[$];
  logic [WB_W-1:0] mon_act, mon_exp;

  // driver tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic drive_ex(input logic v, input logic mr, input logic mw, input logic m2r,
                          input logic rw, input logic wwd, input logic [1:0] rd,
                          input logic [W-1:0] alu, input logic [W-1:0] st);
    ex_valid      = v;
    ex_mem_read   = mr;
    ex_mem_write  = mw;
    ex_mem_to_reg = m2r;
    ex_reg_write  = rw;
    ex_is_wwd     = wwd;
    ex_rd         = rd;
    ex_alu_result = alu;
    ex_store_data = st;
  endtask

  task automatic bubble();
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, '0, '0);
  endtask

  task automatic push_wb(input logic m2r, input logic rw, input logic wwd, input logic [1:0] rd,
                         input logic [W-1:0] alu, input logic [W-1:0] md);
    exp_q.push_back({m2r, rw, wwd, rd, alu, md});
  endtask

  task automatic set_ack(input logic a, input logic [W-1:0] d);
    dmem.d_ack     = a;
    dmem.d_data_in = d;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset_n && wb_valid) begin
      mon_act = {wb_mem_to_reg, wb_reg_write, wb_is_wwd, wb_rd, wb_alu_result, wb_mem_data};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wb_unexpected actual=%h required=no_retire", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          failures++;
          $display("FAIL wb_result actual=%h required=%h", mon_act, mon_exp);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    bubble();
    set_ack(1'b0, '0);

    // reset state
    @(negedge clk);
    check("rst_stall",    32'(mem_stall), 32'd0);
    check("rst_readM",    32'(dmem.d_readM), 32'd0);
    check("rst_writeM",   32'(dmem.d_writeM), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_fsm",      32'(fsm_state), 32'd0);
    check("rst_fwd",      32'(fwd_reg_write), 32'd0);

    // ALU op, rd=2, 0x1234
    reset_n = 1'b1;
    drive_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 16'h1234, 16'h0000);
    push_wb(1'b0, 1'b1, 1'b0, 2'd2, 16'h1234, 16'h0000);
    @(negedge clk);
    check("alu_stall",   32'(mem_stall), 32'd0);
    check("alu_fwd_rw",  32'(fwd_reg_write), 32'd1);
    check("alu_fwd_rd",  32'(fwd_rd), 32'd2);
    check("alu_fwd_val", 32'(fwd_value), 32'h1234);

    // load 0x0040, ack after three WAIT cycles with 0xBEEF; next op held meanwhile
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 16'h0040, 16'h7777);
    push_wb(1'b1, 1'b1, 1'b0, 2'd1, 16'h0040, 16'hBEEF);
    @(negedge clk);
    drive_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 16'h5555, 16'h0000);
    push_wb(1'b0, 1'b1, 1'b0, 2'd3, 16'h5555, 16'hBEEF);
    for (int i = 0; i < 4; i++) begin
      check("ld_readM",  32'(dmem.d_readM), 32'd1);
      check("ld_writeM", 32'(dmem.d_writeM), 32'd0);
      check("ld_addr",   32'(dmem.d_address), 32'h0040);
      check("ld_stall",  32'(mem_stall), 32'd1);
      check("ld_fsm",    32'(fsm_state), (i == 0) ? 32'd0 : 32'd1);
      if (i == 3) set_ack(1'b1, 16'hBEEF);
      @(negedge clk);
    end
    set_ack(1'b0, 16'h0000);
    check("ld_done_fsm",   32'(fsm_state), 32'd2);
    check("ld_done_readM", 32'(dmem.d_readM), 32'd0);
    check("ld_done_stall", 32'(mem_stall), 32'd0);
    check("ld_done_addr",  32'(dmem.d_address), 32'h0000);
    check("ld_fwd_rw",     32'(fwd_reg_write), 32'd0);
    @(negedge clk);
    check("ld_after_fsm",  32'(fsm_state), 32'd0);

    // store 0x00AA to 0x0010, ack in first WAIT
    drive_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0010, 16'h00AA);
    push_wb(1'b0, 1'b0, 1'b0, 2'd0, 16'h0010, 16'hBEEF);
    @(negedge clk);
    drive_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 16'h0101, 16'h0000);
    push_wb(1'b0, 1'b1, 1'b1, 2'd1, 16'h0101, 16'hBEEF);
    for (int i = 0; i < 2; i++) begin
      check("st_writeM", 32'(dmem.d_writeM), 32'd1);
      check("st_readM",  32'(dmem.d_readM), 32'd0);
      check("st_data",   32'(dmem.d_data_out), 32'h00AA);
      check("st_addr",   32'(dmem.d_address), 32'h0010);
      check("st_stall",  32'(mem_stall), 32'd1);
      if (i == 1) set_ack(1'b1, 16'h9999);
      @(negedge clk);
    end
    set_ack(1'b0, 16'h0000);
    check("st_done_writeM", 32'(dmem.d_writeM), 32'd0);
    check("st_done_data",   32'(dmem.d_data_out), 32'h0000);
    check("st_done_stall",  32'(mem_stall), 32'd0);
    check("st_held_value",  32'(fwd_value), 32'h0010);
    @(negedge clk);
    check("st_next_value",  32'(fwd_value), 32'h0101);

    // stray acks on a non-memory op and a bubble
    drive_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0202, 16'h0000);
    push_wb(1'b0, 1'b1, 1'b0, 2'd0, 16'h0202, 16'hBEEF);
    set_ack(1'b1, 16'h1111);
    @(negedge clk);
    check("stray_alu_fsm",   32'(fsm_state), 32'd0);
    check("stray_alu_stall", 32'(mem_stall), 32'd0);
    bubble();
    @(negedge clk);
    check("stray_bub_fsm",   32'(fsm_state), 32'd0);
    check("stray_bub_mdata", 32'(wb_mem_data), 32'hBEEF);
    set_ack(1'b0, 16'h0000);

    // dual-control op with a stray ack in IDLE: must still wait one cycle, read only
    drive_ex(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 16'h0080, 16'h00CC);
    push_wb(1'b1, 1'b1, 1'b0, 2'd2, 16'h0080, 16'hCAFE);
    @(negedge clk);
    bubble();
    set_ack(1'b1, 16'hDEAD);
    check("dual_readM",  32'(dmem.d_readM), 32'd1);
    check("dual_writeM", 32'(dmem.d_writeM), 32'd0);
    check("dual_stall",  32'(mem_stall), 32'd1);
    @(negedge clk);
    check("dual_idle_ack_fsm", 32'(fsm_state), 32'd1);
    check("dual_idle_mdata",   32'(wb_mem_data), 32'hBEEF);
    check("dual_wait_readM",   32'(dmem.d_readM), 32'd1);
    set_ack(1'b1, 16'hCAFE);
    @(negedge clk);
    set_ack(1'b0, 16'h0000);
    check("dual_done_fsm",   32'(fsm_state), 32'd2);
    @(negedge clk);

    // reset pulsed while a load waits for its ack
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 16'h0100, 16'h0000);
    @(negedge clk);
    bubble();
    @(negedge clk);
    check("rw_pre_fsm",   32'(fsm_state), 32'd1);
    check("rw_pre_stall", 32'(mem_stall), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rw_async_readM",    32'(dmem.d_readM), 32'd0);
    check("rw_async_stall",    32'(mem_stall), 32'd0);
    check("rw_async_wb_valid", 32'(wb_valid), 32'd0);
    check("rw_async_fsm",      32'(fsm_state), 32'd0);
    check("rw_async_addr",     32'(dmem.d_address), 32'd0);
    @(negedge clk);
    drive_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 16'h0303, 16'h0000);
    push_wb(1'b0, 1'b1, 1'b0, 2'd1, 16'h0303, 16'h0000);
    reset_n = 1'b1;
    @(negedge clk);
    check("rw_after_fsm",   32'(fsm_state), 32'd0);
    check("rw_after_readM", 32'(dmem.d_readM), 32'd0);
    check("rw_after_stall", 32'(mem_stall), 32'd0);
    check("rw_after_fwd",   32'(fwd_value), 32'h0303);
    bubble();
    @(negedge clk);
    check("rw_no_reissue",  32'(dmem.d_readM), 32'd0);

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter WORD_SIZE, default 16, datapath and address width.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 ex_valid  input  1  EX stage presents a real instruction (0 = bubble).
REQ-005 ex_alu_result  input  WORD_SIZE  ALU result; used as memory address for loads/stores.
REQ-006 ex_store_data  input  WORD_SIZE  store data.
REQ-007 ex_rd  input  2  destination register index.
REQ-008 ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_is_wwd  input  1 each  control bits.
REQ-009 mem_stall  output  1  holds all upstream stages; ex_* are not captured while 1.
REQ-010 d_readM, d_writeM  output  1 each  data-memory read/write request.
REQ-011 d_address  output  WORD_SIZE  memory address.
REQ-012 d_data_out  output  WORD_SIZE  write data.
REQ-013 d_data_in  input  WORD_SIZE  read data, valid when d_ack=1.
REQ-014 d_ack  input  1  memory completion, sampled on rising edge.
REQ-015 wb_valid, wb_mem_to_reg, wb_reg_write, wb_is_wwd  output  1 each  to MEM/WB register.
REQ-016 wb_mem_data, wb_alu_result  output  WORD_SIZE each  to MEM/WB register.
REQ-017 wb_rd  output  2  to MEM/WB register.
REQ-018 fwd_reg_write  output  1, fwd_rd  output  2, fwd_value  output  WORD_SIZE  forwarding to EX.

Function
REQ-019 The EX/MEM latch (valid, alu_result, store_data, rd, five control bits) SHALL load ex_* on each rising edge with mem_stall=0 and SHALL hold while mem_stall=1.
REQ-020 FSM states SHALL be IDLE, WAIT and DONE; a latched op is a memory op if valid & (mem_read | mem_write).
REQ-021 IDLE with latched memory op: request asserted, mem_stall=1, next state WAIT unconditionally; d_ack is ignored in IDLE.
REQ-022 WAIT: request asserted, mem_stall=1; on an edge with d_ack=1, a read SHALL capture d_data_in into mem_data and the FSM SHALL move to DONE; otherwise stay in WAIT (unbounded).
REQ-023 DONE: requests deasserted, mem_stall=0, result presented; next edge loads the latch and returns to IDLE.
REQ-024 Memory op minimum occupancy SHALL be 3 cycles (IDLE, one WAIT with d_ack=1, DONE); non-memory ops and bubbles SHALL occupy 1 cycle with mem_stall=0.
REQ-025 d_readM = latched mem_read in IDLE/WAIT; d_writeM = latched mem_write & !mem_read in IDLE/WAIT; both 0 otherwise.
REQ-026 mem_read and mem_write both set SHALL execute as a read only.
REQ-027 d_address = latched alu_result and d_data_out = latched store_data while a request is asserted, 0 otherwise.
REQ-028 wb_valid = latched valid & (not memory op or state=DONE); when wb_valid=0 all wb_* control bits SHALL be 0.
REQ-029 wb_alu_result, wb_rd, wb_mem_data (mem_data register) SHALL be driven from the latch regardless of wb_valid.
REQ-030 fwd_reg_write = latched valid & reg_write & !mem_to_reg; fwd_rd = latched rd; fwd_value = latched alu_result.
REQ-031 d_ack outside WAIT SHALL have no effect; mem_data SHALL change only on a WAIT read completion.

Reset
REQ-032 reset_n=0 SHALL immediately clear latch valid and all latch fields, mem_data and FSM (to IDLE), forcing every output to 0, including mid-access in WAIT.
REQ-033 After reset_n rises, the first rising edge SHALL load ex_* normally; a pending access aborted by reset SHALL NOT be re-issued.

Verification
REQ-034 ALU op, ex_valid=1, reg_write=1, rd=2, alu=0x1234 -> next cycle wb_valid=1, wb_rd=2, wb_alu_result=0x1234, fwd_reg_write=1, mem_stall=0.
REQ-035 Load addr 0x0040, memory acks after 3 WAIT cycles with 0xBEEF -> d_readM=1, d_address=0x0040 for 4 cycles, mem_stall=1 for 4 cycles, then DONE: wb_mem_data=0xBEEF, wb_valid=1, wb_mem_to_reg=1.
REQ-036 Store addr 0x0010, data 0x00AA, ack in first WAIT -> d_writeM=1 for 2 cycles with d_data_out=0x00AA, wb_reg_write=0, upstream ex_* held and captured only after DONE.
REQ-037 Load stalled in WAIT, reset_n pulsed low -> d_readM, mem_stall, wb_valid fall to 0 asynchronously; after release, FSM IDLE and no request.
REQ-038 Stray d_ack=1 in IDLE and on non-memory ops; mem_read=mem_write=1 -> no state change or mem_data update from strays; dual-control op issues d_readM only.
